// File: rtl/sd_router_pkg.sv
// Shared types and helpers for the SD SPI router: route FSM states and
// lowest-present-slot selection.
package sd_router_pkg;

    typedef enum logic [1:0] {
        S_RUN,
        S_WAIT_IDLE,
        S_SETTLE
    } rt_state_e;

    localparam int unsigned MAX_IMG = 7;
    localparam int unsigned IDX_W   = 3;

    // Lowest set index among the first n bits of v, or n when none is set.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [MAX_IMG-1:0] v,
                                                    input int unsigned n);
        logic [IDX_W-1:0] idx;
        logic             found;
        idx   = IDX_W'(n);
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_IMG; i++) begin
            if (!found && (i < n) && v[i]) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/sd_act_timer.sv
// Activity timer: any change on a or b restarts a saturating counter; act is
// high until the counter reaches TIMEOUT. clr forces the idle state.
module sd_act_timer #(
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic a,
    input  logic b,
    output logic act
);

    localparam int unsigned CW  = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] SAT = CW'(TIMEOUT);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          a_q, a_d;
    logic          b_q, b_d;

    // Edge registers sample every cycle, so a clr also re-arms them.
    always_comb begin
        a_d   = a;
        b_d   = b;
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = SAT;
        end else if ((a != a_q) || (b != b_q)) begin
            cnt_d = '0;
        end else if (cnt_q != SAT) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= SAT;
            a_q   <= 1'b0;
            b_q   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            a_q   <= a_d;
            b_q   <= b_d;
        end
    end

    assign act = (cnt_q < SAT);

endmodule

// File: rtl/sd_router.sv
// Routes the core SPI master to one of NIMG virtual SD images or the physical
// card, switching only after the bus has been idle for SETTLE cycles.
module sd_router
    import sd_router_pkg::*;
#(
    parameter int unsigned NIMG    = 2,
    parameter int unsigned TIMEOUT = 1000000,
    parameter int unsigned SETTLE  = 64,
    parameter int unsigned SW      = $clog2(NIMG + 1)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [NIMG-1:0] img_mounted,
    input  logic [NIMG-1:0] img_present,
    input  logic            sck,
    input  logic            ss,
    input  logic            mosi,
    output logic            miso,
    output logic [NIMG-1:0] vss,
    input  logic [NIMG-1:0] vmiso,
    output logic            phys_cs,
    output logic            phys_sck,
    output logic            phys_mosi,
    input  logic            phys_miso,
    output logic [SW-1:0]   sel,
    output logic            pending,
    output logic [NIMG-1:0] act_img,
    output logic            act_phys
);

    localparam int unsigned   CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] PHYS     = SW'(NIMG);
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

    rt_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [NIMG-1:0] present_q, present_d;
    logic [SW-1:0]   target_c;
    logic            commit_c;
    logic            is_phys_c;
    logic            act_c;

    always_comb begin
        present_d = present_q;
        for (int unsigned i = 0; i < NIMG; i++) begin
            if (img_mounted[i]) present_d[i] = img_present[i];
        end
    end

    assign target_c = SW'(lowest_set(MAX_IMG'(present_q), NIMG));

    // Route FSM: a change waits for ss high, then SETTLE idle cycles.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        commit_c = 1'b0;
        case (state_q)
            S_RUN: begin
                if (target_c != sel_q) state_d = S_WAIT_IDLE;
            end
            S_WAIT_IDLE: begin
                if (target_c == sel_q) begin
                    state_d = S_RUN;
                end else if (ss) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end
            end
            S_SETTLE: begin
                if (target_c == sel_q) begin
                    state_d = S_RUN;
                end else if (!ss) begin
                    state_d = S_WAIT_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    sel_d    = target_c;
                    state_d  = S_RUN;
                    commit_c = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_RUN;
            cnt_q     <= '0;
            sel_q     <= PHYS;
            present_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            present_q <= present_d;
        end
    end

    assign is_phys_c = (sel_q == PHYS);
    assign sel       = sel_q;
    assign pending   = (state_q != S_RUN);
    assign phys_cs   = ss | ~is_phys_c;
    assign phys_sck  = sck & is_phys_c;
    assign phys_mosi = mosi & is_phys_c;
    assign act_phys  = act_c & is_phys_c;

    always_comb begin
        vss     = '1;
        act_img = '0;
        miso    = phys_miso;
        for (int unsigned i = 0; i < NIMG; i++) begin
            if (sel_q == SW'(i)) begin
                vss[i]     = ss;
                miso       = vmiso[i];
                act_img[i] = act_c;
            end
        end
    end

    sd_act_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_act_timer (
        .clock (clock),
        .reset (reset),
        .clr   (commit_c),
        .a     (mosi),
        .b     (miso),
        .act   (act_c)
    );

endmodule

// File: tb/tb_sd_router.sv
// Directed bench for sd_router with NIMG=2, TIMEOUT=16, SETTLE=4.
module tb_sd_router;

    logic       clock;
    logic       reset;
    logic [1:0] img_mounted;
    logic [1:0] img_present;
    logic       sck;
    logic       ss;
    logic       mosi;
    logic       miso;
    logic [1:0] vss;
    logic [1:0] vmiso;
    logic       phys_cs;
    logic       phys_sck;
    logic       phys_mosi;
    logic       phys_miso;
    logic [1:0] sel;
    logic       pending;
    logic [1:0] act_img;
    logic       act_phys;

    int n_vec;
    int n_err;

    sd_router #(
        .NIMG    (2),
        .TIMEOUT (16),
        .SETTLE  (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .img_mounted (img_mounted),
        .img_present (img_present),
        .sck         (sck),
        .ss          (ss),
        .mosi        (mosi),
        .miso        (miso),
        .vss         (vss),
        .vmiso       (vmiso),
        .phys_cs     (phys_cs),
        .phys_sck    (phys_sck),
        .phys_mosi   (phys_mosi),
        .phys_miso   (phys_miso),
        .sel         (sel),
        .pending     (pending),
        .act_img     (act_img),
        .act_phys    (act_phys)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        ss = 1'b1;
        sck = 1'b0;
        mosi = 1'b0;
        img_mounted = 2'b00;
        img_present = 2'b00;
        vmiso = 2'b00;
        phys_miso = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        #1;

        // reset state
        chk("rst_sel", 32'(sel), 32'd2);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_vss", 32'(vss), 32'd3);
        chk("rst_act_img", 32'(act_img), 32'd0);
        chk("rst_act_phys", 32'(act_phys), 32'd0);
        ss = 1'b0; #1;
        chk("phys_cs_lo", 32'(phys_cs), 32'd0);
        chk("vss_ss_lo_phys", 32'(vss), 32'd3);
        ss = 1'b1; #1;
        chk("phys_cs_hi", 32'(phys_cs), 32'd1);
        sck = 1'b1; mosi = 1'b1; #1;
        chk("phys_sck", 32'(phys_sck), 32'd1);
        chk("phys_mosi", 32'(phys_mosi), 32'd1);
        tick();
        chk("act_phys_edge", 32'(act_phys), 32'd1);
        chk("act_img_on_phys", 32'(act_img), 32'd0);

        // mount slot1 with bus idle
        img_mounted = 2'b10; img_present = 2'b10;
        tick();
        img_mounted = 2'b00;
        chk("m1_pending_e0", 32'(pending), 32'd0);
        tick();
        chk("m1_pending_e1", 32'(pending), 32'd1);
        chk("m1_sel_e1", 32'(sel), 32'd2);
        repeat (4) tick();
        chk("m1_sel_e5", 32'(sel), 32'd2);
        tick();
        chk("m1_sel_e6", 32'(sel), 32'd1);
        chk("m1_pending_done", 32'(pending), 32'd0);
        chk("m1_act_cleared", 32'(act_img), 32'd0);
        chk("m1_act_phys", 32'(act_phys), 32'd0);
        chk("m1_phys_sck", 32'(phys_sck), 32'd0);
        ss = 1'b0; #1;
        chk("m1_vss", 32'(vss), 32'd1);
        chk("m1_phys_cs", 32'(phys_cs), 32'd1);

        // mount slot0 during a transfer: route must hold
        img_mounted = 2'b01; img_present = 2'b01;
        tick();
        img_mounted = 2'b00;
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("busy_sel", 32'(sel), 32'd1);
            chk("busy_pending", 32'(pending), 32'd1);
        end
        ss = 1'b1;
        repeat (3) tick();
        ss = 1'b0;
        tick();
        chk("abort_sel", 32'(sel), 32'd1);
        chk("abort_pending", 32'(pending), 32'd1);
        ss = 1'b1;
        repeat (4) tick();
        chk("retry_sel_early", 32'(sel), 32'd1);
        tick();
        chk("retry_sel", 32'(sel), 32'd0);
        chk("retry_pending", 32'(pending), 32'd0);

        // single mosi toggle on slot0
        mosi = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("act0_on", 32'(act_img), 32'd1);
            chk("act0_phys", 32'(act_phys), 32'd0);
        end
        tick();
        chk("act0_off", 32'(act_img), 32'd0);

        // miso mux on slot0
        vmiso = 2'b10; #1;
        chk("miso_v0_lo", 32'(miso), 32'd0);
        vmiso = 2'b01; #1;
        chk("miso_v0_hi", 32'(miso), 32'd1);
        vmiso = 2'b00; phys_miso = 1'b1; #1;
        chk("miso_not_phys", 32'(miso), 32'd0);
        phys_miso = 1'b0;

        // unmount slot0 with traffic up to and including the commit edge
        img_mounted = 2'b01; img_present = 2'b00;
        mosi = ~mosi;
        tick();
        img_mounted = 2'b00;
        for (int i = 0; i < 5; i++) begin
            mosi = ~mosi;
            tick();
        end
        chk("um_sel_pre", 32'(sel), 32'd0);
        chk("um_act_pre", 32'(act_img), 32'd1);
        mosi = ~mosi;
        tick();
        chk("um_sel", 32'(sel), 32'd1);
        chk("um_act_commit", 32'(act_img), 32'd0);
        chk("um_act_phys", 32'(act_phys), 32'd0);
        repeat (5) tick();
        chk("um_act_after", 32'(act_img), 32'd0);
        chk("um_sel_after", 32'(sel), 32'd1);

        // reset in the middle of a settle window
        img_mounted = 2'b01; img_present = 2'b01;
        tick();
        img_mounted = 2'b00;
        tick();
        mosi = ~mosi;
        tick();
        chk("rs_pending", 32'(pending), 32'd1);
        chk("rs_act", 32'(act_img), 32'd2);
        #2 reset = 1'b0;
        #1;
        chk("rs_sel", 32'(sel), 32'd2);
        chk("rs_pending_clr", 32'(pending), 32'd0);
        chk("rs_act_img", 32'(act_img), 32'd0);
        chk("rs_act_phys", 32'(act_phys), 32'd0);
        chk("rs_vss", 32'(vss), 32'd3);
        reset = 1'b1;
        repeat (20) tick();
        chk("post_sel", 32'(sel), 32'd2);
        chk("post_pending", 32'(pending), 32'd0);
        chk("post_act_phys", 32'(act_phys), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
